// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: issues word-aligned bus reads, tags returned
// words with their fetch address and presents them in order to decode.
// A redirect flushes the queue and drops every read still in flight.
module fetch_prefetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        rsp_error,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_address,
   output logic        out_fault
);

   localparam int unsigned QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   // fetch and request state
   logic [31:0]   r_pc;
   logic          r_req_valid;
   logic [31:0]   r_req_addr;
   logic          r_req_stale;
   logic [OW-1:0] r_outstanding;
   logic [OW-1:0] r_drop_count;

   // pending-address FIFO (addresses of accepted reads, oldest first)
   logic [31:0]   r_pend_addr [MAX_OUTSTANDING];
   logic [PW-1:0] r_pend_wr;
   logic [PW-1:0] r_pend_rd;

   // instruction queue
   logic [31:0]   r_q_instr [DEPTH];
   logic [31:0]   r_q_addr  [DEPTH];
   logic          r_q_fault [DEPTH];
   logic [QW-1:0] r_head;
   logic [QW-1:0] r_tail;
   logic [CW-1:0] r_count;

   // next-state values
   logic          w_accept;
   logic          w_hold;
   logic          w_pop;
   logic          w_push;
   logic          w_rsp_drop;
   logic          w_credit;
   logic          w_raise;
   logic [OW-1:0] w_outstanding_nx;
   logic [OW-1:0] w_drop_nx;
   logic [CW-1:0] w_count_nx;
   logic [31:0]   w_pc_nx;
   logic          w_stale_nx;
   logic          w_req_valid_nx;
   logic [31:0]   w_req_addr_nx;

   function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
      return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
   endfunction

   // Event decode, counter updates, redirect override and request credit
   always_comb begin
      w_accept         = r_req_valid && req_ready;
      w_hold           = r_req_valid && !req_ready;
      w_pop            = (r_count != '0) && out_ready;
      w_rsp_drop       = rsp_valid && (r_drop_count != '0);
      w_push           = rsp_valid && (r_drop_count == '0) && !redirect_valid;

      w_outstanding_nx = r_outstanding + OW'(w_accept) - OW'(rsp_valid);
      w_drop_nx        = r_drop_count - OW'(w_rsp_drop) + OW'(w_accept && r_req_stale);
      w_count_nx       = r_count + CW'(w_push) - CW'(w_pop);
      w_pc_nx          = r_pc;
      w_stale_nx       = r_req_stale;

      // a stale request carries a pre-redirect address, so it must not advance pc
      if (w_accept && !r_req_stale) begin
         w_pc_nx = r_pc + 32'd4;
      end
      if (w_accept) begin
         w_stale_nx = 1'b0;
      end

      if (redirect_valid) begin
         w_drop_nx  = w_outstanding_nx;
         w_count_nx = '0;
         w_pc_nx    = {redirect_pc[31:2], 2'b00};
         if (w_hold) begin
            w_stale_nx = 1'b1;
         end
      end

      // every live read must own a queue slot before it is issued
      w_credit = (32'(w_outstanding_nx) < MAX_OUTSTANDING) &&
                 ((32'(w_outstanding_nx) - 32'(w_drop_nx) + 32'(w_count_nx)) < DEPTH);
      w_raise  = !w_hold && !halt && w_credit;

      w_req_valid_nx = w_hold || w_raise;
      w_req_addr_nx  = r_req_addr;
      if (w_raise) begin
         w_req_addr_nx = w_pc_nx;
      end
   end

   // Fetch/request state registers
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_pc          <= RESET_PC;
         r_req_valid   <= 1'b0;
         r_req_addr    <= RESET_PC;
         r_req_stale   <= 1'b0;
         r_outstanding <= '0;
         r_drop_count  <= '0;
         r_count       <= '0;
      end else begin
         r_pc          <= w_pc_nx;
         r_req_valid   <= w_req_valid_nx;
         r_req_addr    <= w_req_addr_nx;
         r_req_stale   <= w_stale_nx;
         r_outstanding <= w_outstanding_nx;
         r_drop_count  <= w_drop_nx;
         r_count       <= w_count_nx;
      end
   end

   // Pending-address FIFO: push on acceptance, pop on every response
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_pend_wr <= '0;
         r_pend_rd <= '0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            r_pend_addr[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_pend_addr[r_pend_wr] <= r_req_addr;
            r_pend_wr              <= pend_inc(r_pend_wr);
         end
         if (rsp_valid) begin
            r_pend_rd <= pend_inc(r_pend_rd);
         end
      end
   end

   // Instruction queue storage and pointers; redirect empties it
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_head <= '0;
         r_tail <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_q_instr[i] <= '0;
            r_q_addr[i]  <= '0;
            r_q_fault[i] <= 1'b0;
         end
      end else if (redirect_valid) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_push) begin
            r_q_instr[r_tail] <= rsp_error ? 32'd0 : rsp_data;
            r_q_addr[r_tail]  <= r_pend_addr[r_pend_rd];
            r_q_fault[r_tail] <= rsp_error;
            r_tail            <= r_tail + QW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + QW'(1);
         end
      end
   end

   assign req_valid       = r_req_valid;
   assign req_addr        = r_req_addr;
   assign out_valid       = (r_count != '0);
   assign out_instruction = r_q_instr[r_head];
   assign out_address     = r_q_addr[r_head];
   assign out_fault       = r_q_fault[r_head];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue. The reference model treats the
// decode stream as a run of consecutive word addresses that restarts at every
// redirect (and at reset); memory contents and bus errors are pure functions
// of the address.
module tb_fetch_prefetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAXO     = 2;

   logic        clock = 1'b0;
   logic        nreset;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_address;
   logic        out_fault;

   logic        wr_req_valid;
   logic [31:0] wr_req_addr;
   logic        wr_rsp_valid;
   logic [31:0] wr_rsp_data;
   logic        wr_out_valid;
   logic [31:0] wr_out_instruction;
   logic [31:0] wr_out_address;
   logic        wr_out_fault;

   fetch_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) u_dut (
      .clock(clock), .nreset(nreset), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
      .out_address(out_address), .out_fault(out_fault)
   );

   fetch_prefetch_queue #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) u_dut_wrap (
      .clock(clock), .nreset(nreset), .halt(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'd0),
      .req_valid(wr_req_valid), .req_ready(1'b1), .req_addr(wr_req_addr),
      .rsp_valid(wr_rsp_valid), .rsp_data(wr_rsp_data), .rsp_error(1'b0),
      .out_valid(wr_out_valid), .out_ready(1'b1), .out_instruction(wr_out_instruction),
      .out_address(wr_out_address), .out_fault(wr_out_fault)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // stimulus knobs
   int p_rready, p_oready, p_halt, p_redir, lat_min, lat_max;
   int err_mode;
   logic [31:0] err_addr;
   bit          force_redir;
   logic [31:0] force_pc;

   // bus model and reference state
   logic [31:0] bq_addr[$];
   int          bq_due[$];
   logic [31:0] wq[$];
   int          last_due;
   int          cyc;
   logic [31:0] exp_addr;
   logic [31:0] wr_exp;
   int          wr_n;
   int          n_xfer, last_xfer_cyc, n_outv;
   int          first_req_cyc, first_out_cyc;
   bit          saw_fault;
   bit          prev_redir, prev_out_stall, prev_req_stall, prev_out_f;
   logic [31:0] prev_out_a, prev_out_i, prev_req_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      logic [31:0] h;
      h = mem_word(a);
      if (err_mode == 1) return (a == err_addr);
      if (err_mode == 2) return (h[3:0] == 4'd0);
      return 1'b0;
   endfunction

   function automatic logic [31:0] pick_pc();
      if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      return $urandom;
   endfunction

   // one clock cycle: observe at negedge, drive inputs, predict the next edge
   task automatic tick();
      int r, lat, due;
      logic [31:0] a;
      logic [31:0] exp_i;
      bit          e;

      if (req_valid && first_req_cyc < 0) first_req_cyc = cyc;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid) n_outv++;
      check("req_align", {30'd0, req_addr[1:0]}, 32'd0);
      check("outstanding_max", 32'(bq_addr.size() <= int'(MAXO)), 32'd1);
      if (prev_redir) begin
         check("flush_out_valid", 32'(out_valid), 32'd0);
      end else if (prev_out_stall) begin
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_addr", out_address, prev_out_a);
         check("hold_out_instr", out_instruction, prev_out_i);
         check("hold_out_fault", 32'(out_fault), 32'(prev_out_f));
      end
      if (prev_req_stall) begin
         check("hold_req_valid", 32'(req_valid), 32'd1);
         check("hold_req_addr", req_addr, prev_req_addr);
      end

      r = int'($urandom_range(99)); req_ready = (r < p_rready);
      r = int'($urandom_range(99)); out_ready = (r < p_oready);
      r = int'($urandom_range(99)); halt      = (r < p_halt);
      r = int'($urandom_range(99));
      redirect_valid = force_redir || (r < p_redir);
      redirect_pc    = force_redir ? force_pc : pick_pc();
      force_redir    = 1'b0;

      if (bq_addr.size() != 0 && bq_due[0] <= cyc) begin
         a         = bq_addr.pop_front();
         due       = bq_due.pop_front();
         rsp_valid = 1'b1;
         rsp_error = is_err(a);
         rsp_data  = mem_word(a);
      end else begin
         rsp_valid = 1'b0;
         rsp_error = 1'($urandom_range(1));
         rsp_data  = $urandom;
      end

      if (req_valid && req_ready) begin
         lat = int'($urandom_range(lat_max, lat_min));
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         bq_addr.push_back(req_addr);
         bq_due.push_back(due);
      end
      if (out_valid && out_ready) begin
         e     = is_err(exp_addr);
         exp_i = e ? 32'd0 : mem_word(exp_addr);
         check("out_addr", out_address, exp_addr);
         check("out_fault", 32'(out_fault), 32'(e));
         check("out_instr", out_instruction, exp_i);
         if (err_mode == 1 && exp_addr == err_addr && out_fault) saw_fault = 1'b1;
         exp_addr      = exp_addr + 32'd4;
         n_xfer++;
         last_xfer_cyc = cyc;
      end
      if (redirect_valid) exp_addr = {redirect_pc[31:2], 2'b00};

      prev_redir     = redirect_valid;
      prev_out_stall = out_valid && !out_ready;
      prev_out_a     = out_address;
      prev_out_i     = out_instruction;
      prev_out_f     = out_fault;
      prev_req_stall = req_valid && !req_ready;
      prev_req_addr  = req_addr;

      // wrap instance: always-ready bus with one-cycle latency
      if (wr_out_valid) begin
         if (wr_n < 4) begin
            check("wrap_addr", wr_out_address, wr_exp);
            check("wrap_instr", wr_out_instruction, mem_word(wr_exp));
            wr_n++;
         end
         wr_exp = wr_exp + 32'd4;
      end
      if (wq.size() != 0) begin
         a            = wq.pop_front();
         wr_rsp_valid = 1'b1;
         wr_rsp_data  = mem_word(a);
      end else begin
         wr_rsp_valid = 1'b0;
         wr_rsp_data  = $urandom;
      end
      if (wr_req_valid) wq.push_back(wr_req_addr);

      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   task automatic do_reset();
      nreset         = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      rsp_data       = 32'd0;
      rsp_error      = 1'b0;
      out_ready      = 1'b0;
      wr_rsp_valid   = 1'b0;
      wr_rsp_data    = 32'd0;
      #1;
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_req_addr", req_addr, RESET_PC);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instruction, 32'd0);
      check("rst_out_addr", out_address, 32'd0);
      check("rst_out_fault", 32'(out_fault), 32'd0);
      check("rst_wrap_req_addr", wr_req_addr, WRAP_PC);
      bq_addr.delete();
      bq_due.delete();
      wq.delete();
      last_due       = 0;
      exp_addr       = RESET_PC;
      wr_exp         = WRAP_PC;
      prev_redir     = 1'b0;
      prev_out_stall = 1'b0;
      prev_req_stall = 1'b0;
      repeat (2) @(negedge clock);
      nreset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int x0, guard;
      nreset = 1'b0;
      cyc = 0; n_xfer = 0; last_xfer_cyc = 0; n_outv = 0; wr_n = 0;
      first_req_cyc = -1; first_out_cyc = -1; saw_fault = 1'b0;
      force_redir = 1'b0; force_pc = 32'd0;
      err_mode = 1; err_addr = 32'h8;
      p_rready = 100; p_oready = 100; p_halt = 0; p_redir = 0; lat_min = 1; lat_max = 1;
      @(negedge clock);
      do_reset();

      // latency and steady-state throughput, fault on 0x8
      repeat (12) tick();
      check("first_out_latency", 32'(first_out_cyc - first_req_cyc), 32'd2);
      n_outv = 0;
      repeat (20) tick();
      check("steady_rate", 32'(n_outv), 32'd20);
      check("fault_seen", 32'(saw_fault), 32'd1);

      // decode stall: queue fills to DEPTH and fetch stops
      p_oready = 0;
      repeat (20) tick();
      check("stall_req_valid", 32'(req_valid), 32'd0);
      check("stall_inflight", 32'(bq_addr.size()), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      p_rready = 0; p_oready = 100; x0 = n_xfer;
      repeat (8) tick();
      check("stall_depth", 32'(n_xfer - x0), DEPTH);

      // redirect with two reads in flight
      p_rready = 100; p_oready = 0; lat_min = 4; lat_max = 4;
      guard = 0;
      while (bq_addr.size() != 2 && guard < 50) begin tick(); guard++; end
      check("redir_setup", 32'(bq_addr.size()), 32'd2);
      force_redir = 1'b1; force_pc = 32'h0000_1002;
      tick();
      p_oready = 100; x0 = n_xfer; guard = 0;
      while (n_xfer < x0 + 2 && guard < 60) begin tick(); guard++; end
      check("redir_progress", 32'(n_xfer >= x0 + 2), 32'd1);

      // redirect together with halt: pc moves, no request until halt drops
      p_halt = 100; force_redir = 1'b1; force_pc = 32'h0000_2000;
      repeat (12) tick();
      check("halt_req_valid", 32'(req_valid), 32'd0);
      check("halt_inflight", 32'(bq_addr.size()), 32'd0);
      p_halt = 0; x0 = n_xfer; guard = 0;
      while (n_xfer < x0 + 3 && guard < 60) begin tick(); guard++; end
      check("halt_resume", 32'(n_xfer >= x0 + 3), 32'd1);

      // random traffic with redirects, halts and bus errors
      err_mode = 2; p_rready = 70; p_oready = 70; p_halt = 10; p_redir = 3;
      lat_min = 1; lat_max = 5; x0 = n_xfer; last_xfer_cyc = cyc;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (cyc - last_xfer_cyc > 300) begin
            check("random_watchdog", 32'(cyc - last_xfer_cyc), 32'd0);
            break;
         end
      end
      check("random_progress", 32'(n_xfer > x0 + 500), 32'd1);

      // asynchronous reset mid-stream with two reads in flight
      p_halt = 0; p_redir = 0; p_rready = 100; p_oready = 100; lat_min = 4; lat_max = 4;
      guard = 0;
      while (bq_addr.size() != 2 && guard < 50) begin tick(); guard++; end
      check("reset_setup", 32'(bq_addr.size()), 32'd2);
      do_reset();
      lat_min = 1; lat_max = 1; x0 = n_xfer;
      repeat (20) tick();
      check("reset_restart", 32'(n_xfer >= x0 + 10), 32'd1);
      check("wrap_count", 32'(wr_n), 32'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
